master_axi_s_interface: RTL
===========================

MASTER_AXI_S_INTERFACE -- requirements
Module: master_axi_s_interface

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the sample/word width on both sides.
REQ-002 Parameter FRAME_SIZE, default 1920, SHALL set the number of AXI-Stream beats per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the number of FIFO entries.
REQ-004 ACLK  input  1  SHALL be the clock; all logic is rising-edge.
REQ-005 ARESET_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 VALID  input  1  SHALL indicate that core word SAMPLE is valid.
REQ-007 READY  output  1  SHALL indicate that the block accepts a core word this cycle.
REQ-008 SAMPLE  input  DATA_W  SHALL carry the core word.
REQ-009 LAST  input  1  SHALL mark the core's final word of a frame.
REQ-010 TVALID  output  1  SHALL be the AXI-Stream master valid.
REQ-011 TREADY  input  1  SHALL be the downstream ready.
REQ-012 TDATA  output  DATA_W  SHALL be the AXI-Stream data.
REQ-013 TLAST  output  1  SHALL mark the final beat of a frame.
REQ-014 TUSER  output  1  SHALL mark the first beat of a frame.
REQ-015 FRAME_ERR  output  1  SHALL be the sticky frame-alignment error flag.

Function
REQ-016 Push SHALL occur on VALID && READY; READY SHALL equal !full, with no combinational path from TREADY.
REQ-017 Pop SHALL occur on TVALID && TREADY; TVALID SHALL equal !empty, registered.
REQ-018 TDATA SHALL present the FIFO head; TDATA, TLAST and TUSER SHALL stay stable while TVALID && !TREADY.
REQ-019 Latency: a word pushed at edge N into an empty FIFO SHALL appear with TVALID=1 after edge N, with no same-cycle pass-through.
REQ-020 Full, simultaneous pop: READY SHALL stay 0 that cycle and rise after the pop edge.
REQ-021 Empty, simultaneous push: the word SHALL be stored and no pop SHALL occur.
REQ-022 An output beat counter 0..FRAME_SIZE-1 SHALL increment on each pop and wrap to 0 after the beat with count FRAME_SIZE-1.
REQ-023 TUSER SHALL be 1 when the head beat's count is 0; TLAST SHALL be 1 when it is FRAME_SIZE-1.
REQ-024 TLAST SHALL be derived only from the beat counter; input LAST SHALL NOT alter TLAST.
REQ-025 Pointer arithmetic SHALL be modulo FIFO_DEPTH, with an extra wrap bit distinguishing full from empty.

Reset
REQ-026 While ARESET_N=0: TVALID=0, READY=0, TDATA=0, TLAST=0, TUSER=0, FRAME_ERR=0, with pointers and all counters cleared.
REQ-027 Reset mid-frame SHALL discard all FIFO contents; the first beat after release SHALL carry TUSER=1.
REQ-028 READY SHALL rise in the first cycle after ARESET_N deasserts.

Configuration
REQ-029 With MASTER_AXIS_FRAME_CHECK_EN defined, an input word counter SHALL track pushes modulo FRAME_SIZE.
REQ-030 With the macro defined, FRAME_ERR SHALL set on either of two conditions: LAST pushed at a count other than FRAME_SIZE-1, or count FRAME_SIZE-1 pushed with LAST=0. FRAME_ERR SHALL then hold until reset.
REQ-031 Without the macro, no input counter SHALL exist and FRAME_ERR SHALL be constant 0.

Structure
REQ-032 Package lpc_axis_pkg SHALL hold the DATA_W, FRAME_SIZE and FIFO_DEPTH defaults and the beat-counter width constant, shared with slave_axi_s_interface.
REQ-033 Storage SHALL be a sub-module axis_sync_fifo containing the pointers and full/empty logic; the counters, TUSER/TLAST generation and checking SHALL live in the top level.

Verification
REQ-034 Scenario: FRAME_ERR must stay 0 throughout.
- Stimulus: TREADY=1, core streams 1..3840 with LAST on words 1920 and 3840.
- Required response: TUSER on data 1 and 1921, TLAST on 1920 and 3840.
REQ-035 Scenario: backpressure fills the FIFO.
- Stimulus: TREADY=0 while 6 words are offered.
- Required response: READY falls after 4 pushes, TDATA holds the first word, and after TREADY=1 all 6 words emerge in order.
REQ-036 Scenario: data loss is forbidden throughout.
- Stimulus: TREADY random 50% against continuous VALID.
- Required response: TDATA is stable while stalled and output order matches input.
REQ-037 Scenario: early LAST.
- Stimulus: LAST asserted on word 100, with the macro defined.
- Required response: FRAME_ERR=1 on the next cycle and stays set; TLAST still occurs on beat 1920.
REQ-038 Scenario: reset mid-frame.
- Stimulus: ARESET_N pulsed low at beat 500 with 3 words buffered.
- Required response: outputs go to 0 immediately, and the next beat carries TUSER=1 with the first post-reset word.
REQ-039 Scenario: single word into an empty FIFO.
- Stimulus: one word pushed into the empty FIFO.
- Required response: TVALID=1 exactly one cycle later.

Source files
------------

// File: rtl/lpc_axis_pkg.sv
// lpc_axis_pkg: shared defaults and the beat-counter width helper for the LPC AXI-Stream bridges.
package lpc_axis_pkg;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FRAME_SIZE = 1920;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEAT_W = cnt_w(DEF_FRAME_SIZE);
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module axis_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              ACLK,
    input  logic              ARESET_N,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/master_axi_s_interface.sv
// master_axi_s_interface: core-word to AXI-Stream master bridge; frame tags come from an output beat counter.
// Defining MASTER_AXIS_FRAME_CHECK_EN adds an input word counter that drives the sticky FRAME_ERR flag.
module master_axi_s_interface
    import lpc_axis_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_SIZE = DEF_FRAME_SIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              ACLK,
    input  logic              ARESET_N,
    input  logic              VALID,
    output logic              READY,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic              LAST,
    output logic              TVALID,
    input  logic              TREADY,
    output logic [DATA_W-1:0] TDATA,
    output logic              TLAST,
    output logic              TUSER,
    output logic              FRAME_ERR
);
    localparam int CW = cnt_w(FRAME_SIZE);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_SIZE - 1);
    logic              run, full, empty, push, pop;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     out_cnt;
    // run holds READY low until the first edge after reset release
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) run <= 1'b0;
        else run <= 1'b1;
    end
    assign READY  = run && !full;
    assign TVALID = !empty;
    assign push   = VALID && READY;
    assign pop    = TVALID && TREADY;
    axis_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .ACLK(ACLK),
        .ARESET_N(ARESET_N),
        .push(push),
        .wdata(SAMPLE),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) out_cnt <= '0;
        else if (pop) out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + CW'(1);
    end
    assign TDATA = TVALID ? head : '0;
    assign TUSER = TVALID && out_cnt == '0;
    assign TLAST = TVALID && out_cnt == LAST_BEAT;
`ifdef MASTER_AXIS_FRAME_CHECK_EN
    logic [CW-1:0] in_cnt;
    logic          err;
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            in_cnt <= '0;
            err    <= 1'b0;
        end else if (push) begin
            in_cnt <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + CW'(1);
            err    <= err || (LAST != (in_cnt == LAST_BEAT));
        end
    end
    assign FRAME_ERR = err;
`else
    logic unused_last;
    assign unused_last = LAST;
    assign FRAME_ERR   = 1'b0;
`endif
endmodule
